// File: rtl/io_latch_bank.sv
// rtl/io_latch_bank.sv - bus-side output latch bank with synchronised input port and sticky status
module io_latch_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int ADDR_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      latch_wren,
    input  logic [ADDR_W-1:0]         latch_address_w,
    input  logic [ADDR_W-1:0]         latch_address_r,
    input  logic [WIDTH-1:0]          merge_in,
    input  logic [WIDTH-1:0]          IO_in,
    input  logic [CHANNELS-1:0]       ack_in,
    output logic [WIDTH-1:0]          merge_out,
    output logic [CHANNELS*WIDTH-1:0] latch_out,
    output logic [CHANNELS-1:0]       dirty,
    output logic                      io_change
);

    localparam logic [ADDR_W-1:0] IN_ADDR = ADDR_W'(CHANNELS);
    localparam logic [ADDR_W-1:0] ST_ADDR = ADDR_W'(CHANNELS + 1);

    logic [WIDTH-1:0]    latch_q [CHANNELS];
    logic [WIDTH-1:0]    latch_d [CHANNELS];
    logic [CHANNELS-1:0] dirty_q, dirty_d;
    logic [WIDTH-1:0]    s1_q, s2_q, prev_q;
    logic                chg_sticky_q, chg_sticky_d;
    logic [WIDTH-1:0]    merge_out_q, merge_out_d;
    logic                io_change_q;
    logic                change;
    logic [WIDTH-1:0]    status;

    assign change = (s2_q != prev_q);
    assign status = {{(WIDTH-2){1'b0}}, |dirty_q, chg_sticky_q};

    // Set wins over ack on the same channel.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            latch_d[i] = latch_q[i];
            dirty_d[i] = dirty_q[i] & ~ack_in[i];
            if (latch_wren && (latch_address_w == ADDR_W'(i))) begin
                latch_d[i] = merge_in;
                dirty_d[i] = 1'b1;
            end
        end
    end

    // Read mux works on pre-edge state, so a same-edge write returns the old value.
    always_comb begin
        merge_out_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (latch_address_r == ADDR_W'(i)) begin
                merge_out_d = latch_q[i];
            end
        end
        if (latch_address_r == IN_ADDR) begin
            merge_out_d = s2_q;
        end
        if (latch_address_r == ST_ADDR) begin
            merge_out_d = status;
        end
    end

    assign chg_sticky_d = change | (chg_sticky_q & (latch_address_r != ST_ADDR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                latch_q[i] <= '0;
            end
            dirty_q      <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            prev_q       <= '0;
            chg_sticky_q <= 1'b0;
            merge_out_q  <= '0;
            io_change_q  <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                latch_q[i] <= latch_d[i];
            end
            dirty_q      <= dirty_d;
            s1_q         <= IO_in;
            s2_q         <= s1_q;
            prev_q       <= s2_q;
            chg_sticky_q <= chg_sticky_d;
            merge_out_q  <= merge_out_d;
            io_change_q  <= change;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lat
        assign latch_out[g*WIDTH +: WIDTH] = latch_q[g];
    end

    assign merge_out = merge_out_q;
    assign dirty     = dirty_q;
    assign io_change = io_change_q;

endmodule

// File: tb/tb_io_latch_bank.sv
// tb/tb_io_latch_bank.sv - self-checking bench for io_latch_bank
module tb_io_latch_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        latch_wren;
    logic [2:0]  latch_address_w, latch_address_r;
    logic [7:0]  merge_in, IO_in;
    logic [3:0]  ack_in;
    logic [7:0]  merge_out;
    logic [31:0] latch_out;
    logic [3:0]  dirty;
    logic        io_change;

    int checks = 0;
    int errors = 0;

    io_latch_bank #(.WIDTH(8), .CHANNELS(4), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .latch_wren(latch_wren),
        .latch_address_w(latch_address_w), .latch_address_r(latch_address_r),
        .merge_in(merge_in), .IO_in(IO_in), .ack_in(ack_in),
        .merge_out(merge_out), .latch_out(latch_out), .dirty(dirty),
        .io_change(io_change)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wren;
        logic [2:0]  aw;
        logic [2:0]  ar;
        logic [7:0]  mi;
        logic [3:0]  ack;
        logic [7:0]  e_mo;
        logic [3:0]  e_dirty;
        logic [31:0] e_lat;
    } vec_t;

    vec_t vec [14];

    // Reference model state
    bit [7:0] m_lat [4];
    bit [3:0] m_dirty;
    bit [7:0] m_q [$];
    bit       m_sticky;
    bit [7:0] m_mo;
    bit       m_chg;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [2:0] aw, input logic [2:0] ar,
                         input logic [7:0] mi, input logic [3:0] ack);
        latch_wren = w; latch_address_w = aw; latch_address_r = ar;
        merge_in = mi; ack_in = ack;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_lat[i] = 0;
        m_dirty = 0; m_q.delete(); m_sticky = 0; m_mo = 0; m_chg = 0;
    endfunction

    // s2 is the input as sampled two edges ago, prev three edges ago.
    function automatic void model_edge();
        bit [7:0] s2, prev, rd;
        bit ch;
        int n = m_q.size();
        s2   = (n >= 2) ? m_q[n-2] : 8'h00;
        prev = (n >= 3) ? m_q[n-3] : 8'h00;
        if (latch_address_r < 4)       rd = m_lat[latch_address_r];
        else if (latch_address_r == 4) rd = s2;
        else if (latch_address_r == 5) rd = {6'b0, |m_dirty, m_sticky};
        else                           rd = 8'h00;
        ch = (s2 != prev);
        m_mo = rd;
        m_chg = ch;
        m_sticky = ch || (m_sticky && latch_address_r != 5);
        for (int i = 0; i < 4; i++) begin
            if (latch_wren && latch_address_w == i) begin
                m_lat[i] = merge_in;
                m_dirty[i] = 1'b1;
            end else if (ack_in[i]) begin
                m_dirty[i] = 1'b0;
            end
        end
        m_q.push_back(IO_in);
        if (m_q.size() > 3) void'(m_q.pop_front());
    endfunction

    initial begin
        int pulses, pulse_edge;

        vec[0]  = '{1'b1, 3'd0, 3'd0, 8'h11, 4'h0, 8'h00, 4'h1, 32'h00000011};
        vec[1]  = '{1'b1, 3'd1, 3'd0, 8'h22, 4'h0, 8'h11, 4'h3, 32'h00002211};
        vec[2]  = '{1'b1, 3'd2, 3'd1, 8'h33, 4'h0, 8'h22, 4'h7, 32'h00332211};
        vec[3]  = '{1'b1, 3'd3, 3'd2, 8'h44, 4'h0, 8'h33, 4'hF, 32'h44332211};
        vec[4]  = '{1'b0, 3'd0, 3'd3, 8'h00, 4'h0, 8'h44, 4'hF, 32'h44332211};
        vec[5]  = '{1'b1, 3'd2, 3'd2, 8'hA5, 4'h0, 8'h33, 4'hF, 32'h44A52211};
        vec[6]  = '{1'b0, 3'd0, 3'd2, 8'h00, 4'h0, 8'hA5, 4'hF, 32'h44A52211};
        vec[7]  = '{1'b1, 3'd4, 3'd5, 8'hEE, 4'h0, 8'h02, 4'hF, 32'h44A52211};
        vec[8]  = '{1'b1, 3'd5, 3'd4, 8'hEE, 4'h0, 8'h00, 4'hF, 32'h44A52211};
        vec[9]  = '{1'b1, 3'd7, 3'd0, 8'hEE, 4'h0, 8'h11, 4'hF, 32'h44A52211};
        vec[10] = '{1'b1, 3'd1, 3'd1, 8'h66, 4'h2, 8'h22, 4'hF, 32'h44A56611};
        vec[11] = '{1'b0, 3'd0, 3'd1, 8'h00, 4'h2, 8'h66, 4'hD, 32'h44A56611};
        vec[12] = '{1'b0, 3'd0, 3'd3, 8'h00, 4'hF, 8'h44, 4'h0, 32'h44A56611};
        vec[13] = '{1'b0, 3'd0, 3'd5, 8'h00, 4'h0, 8'h00, 4'h0, 32'h44A56611};

        rst = 1'b1; IO_in = 8'h00;
        drive(1'b0, 3'd0, 3'd0, 8'h00, 4'h0);
        tick(); tick();
        chk("reset merge_out", merge_out, 8'h00);
        chk("reset latch_out", latch_out, 32'h0);
        chk("reset dirty", dirty, 4'h0);
        chk("reset io_change", io_change, 1'b0);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vec[i].wren, vec[i].aw, vec[i].ar, vec[i].mi, vec[i].ack);
            tick();
            chk($sformatf("vec%0d merge_out", i), merge_out, vec[i].e_mo);
            chk($sformatf("vec%0d dirty", i), dirty, vec[i].e_dirty);
            chk($sformatf("vec%0d latch_out", i), latch_out, vec[i].e_lat);
            chk($sformatf("vec%0d io_change", i), io_change, 1'b0);
        end

        // Input change 0x00 -> 0x5A: single pulse three edges later
        drive(1'b0, 3'd0, 3'd4, 8'h00, 4'h0);
        IO_in = 8'h5A;
        pulses = 0; pulse_edge = 0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (io_change) begin pulses++; pulse_edge = e; end
        end
        chk("io pulse count", pulses, 1);
        chk("io pulse edge", pulse_edge, 3);
        chk("read IN_ADDR", merge_out, 8'h5A);
        latch_address_r = 3'd5; tick();
        chk("status sticky", merge_out, 8'h01);
        tick();
        chk("status cleared", merge_out, 8'h00);

        // Change detected on the same edge as the clearing status read
        latch_address_r = 3'd0;
        IO_in = 8'hA0; tick();
        IO_in = 8'h0A; tick();
        tick();
        chk("b2b pulse 1", io_change, 1'b1);
        latch_address_r = 3'd5; tick();
        chk("b2b pulse 2", io_change, 1'b1);
        chk("status pre-clear", merge_out, 8'h01);
        tick();
        chk("sticky set wins", merge_out, 8'h01);
        chk("pulse ends", io_change, 1'b0);
        tick();
        chk("sticky cleared", merge_out, 8'h00);

        // Asynchronous reset in the middle of a write
        drive(1'b1, 3'd0, 3'd1, 8'hFF, 4'h0);
        tick();
        chk("pre-reset merge_out", merge_out, 8'h66);
        chk("pre-reset dirty", dirty, 4'h1);
        @(negedge clk); #2; rst = 1'b1; #1;
        chk("async rst merge_out", merge_out, 8'h00);
        chk("async rst latch_out", latch_out, 32'h0);
        chk("async rst dirty", dirty, 4'h0);
        chk("async rst io_change", io_change, 1'b0);
        IO_in = 8'h00;
        drive(1'b0, 3'd0, 3'd0, 8'h00, 4'h0);
        tick();
        @(negedge clk); rst = 1'b0;
        model_reset();

        // Randomised run against the reference model
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 1), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  8'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
            if ($urandom_range(0, 9) < 3) IO_in = 8'($urandom);
            @(posedge clk);
            model_edge();
            #1;
            chk("rand merge_out", merge_out, m_mo);
            chk("rand latch_out", latch_out, {m_lat[3], m_lat[2], m_lat[1], m_lat[0]});
            chk("rand dirty", dirty, m_dirty);
            chk("rand io_change", io_change, m_chg);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
